lsb_queue: RTL and testbench
============================

Name: lsb_queue

Overview:
Parameterised in-order load/store buffer for the out-of-order RISC-V core, sitting between the dispatcher, the CDB and the LSU.
- Holds up to DEPTH memory ops in a circular queue.
- Snoops NUM_CDB broadcast channels for operand wake-up.
- Issues the head entry to the LSU through a registered valid/ready stage.
- Gates stores on ROB commit and IO-address loads on ROB-head position.
- On misprediction flush, drops all uncommitted entries and keeps committed stores so they still drain.

Parameters:
DEPTH, 16, entry count; power of two, at least 4
ROB_W, 4, ROB id width; id 0 means "no dependency"
DATA_W, 32, data/address width
OP_W, 6, opcode width
NUM_CDB, 2, number of CDB broadcast channels (ALU, LSU, ...)
FULL_MARGIN, 3, full asserts when count >= DEPTH-FULL_MARGIN
IO_ADDR, 32'h30000, memory-mapped IO address

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; low freezes all state
flush  in  1  misprediction rollback
disp_valid  in  1  enqueue request
disp_op  in  OP_W  opcode
disp_is_store  in  1  1=store, 0=load
disp_q1, disp_q2  in  ROB_W  producer ROB ids for base and store data
disp_v1, disp_v2  in  DATA_W  operand values, valid when q=0
disp_imm  in  DATA_W  address offset
disp_rob  in  ROB_W  ROB id of this op
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_rob  in  NUM_CDB*ROB_W  packed ROB ids, channel 0 in LSBs
cdb_data  in  NUM_CDB*DATA_W  packed results
commit_valid  in  1  ROB commit strobe
commit_rob  in  ROB_W  committed ROB id
rob_head_id  in  ROB_W  ROB id at the ROB head
lsu_valid  out  1  request to LSU (registered)
lsu_ready  in  1  LSU accepts
lsu_op  out  OP_W  opcode
lsu_is_store  out  1  store flag
lsu_addr  out  DATA_W  v1+imm, modulo 2^DATA_W
lsu_data  out  DATA_W  store data; 0 for loads
lsu_rob  out  ROB_W  ROB id
count  out  clog2(DEPTH)+1  occupancy
full  out  1  backpressure to dispatcher

Behaviour:
- Reset: head=tail=count=0; all busy/committed bits 0; lsu_valid=0; lsu_op, lsu_is_store, lsu_addr, lsu_data, lsu_rob all 0; full=0.
- rdy=0: no state changes; outputs hold.
- Enqueue: when disp_valid and count<DEPTH, write entry at tail, tail wraps DEPTH-1 -> 0. When count==DEPTH, disp_valid is ignored.
- Same-cycle bypass on enqueue: if disp_qX equals the cdb_rob of any valid channel, store qX=0 and vX=that channel's data. q=0 never matches.
- Wake-up: every busy entry with qX equal to a valid channel's ROB id gets qX<=0 and vX<=data. Effect is visible next cycle.
- Commit: the busy entry whose rob equals commit_rob gets committed<=1.
- Head eligible when all of:
  - busy, q1==0 and q2==0;
  - store: committed==1;
  - load: (v1+imm)!=IO_ADDR, or rob_head_id==rob.
- Output stage:
  - "free" = !lsu_valid || lsu_ready.
  - If free and head eligible: load the outputs, set lsu_valid=1, clear the head entry, advance head with wrap.
  - If free and head not eligible: lsu_valid<=0.
  - Otherwise hold all outputs.
  - Latency: 1 cycle from eligibility to lsu_valid. Back-to-back issue is allowed, one op per accepted handshake.
- count: count + enqueue - pop. Both in the same cycle leaves it unchanged. full = count>=DEPTH-FULL_MARGIN.
- Flush (priority over enqueue and issue that cycle):
  - Clear every entry with committed==0.
  - Committed entries are contiguous from head, so tail<=head+ncommitted (mod DEPTH) and count<=ncommitted.
  - A pending lsu_valid load is dropped (lsu_valid<=0).
  - A pending store holds until accepted.
  - A commit_valid arriving in the same cycle as flush is applied before the clear.
- Wake-up, commit and enqueue may all hit in one cycle. They touch distinct fields or entries, and all apply.

Test Plan:
- Reset, then enqueue load {v1=0x100, imm=4, q=0} with lsu_ready=1 -> lsu_valid next cycle, lsu_addr=0x104, lsu_data=0, count returns to 0.
- Enqueue store with q2=5, commit_rob=5 never committed; then CDB ch1 broadcasts rob 5 data 0xDEAD and commit_valid with the store's rob -> issue only after commit, lsu_data=0xDEAD.
- Enqueue with q1=3 while CDB ch0 broadcasts rob 3 data 0x200 in the same cycle -> entry ready immediately, lsu_addr=0x200+imm.
- Load to 0x30000 with rob 7, rob_head_id=2 -> no issue; rob_head_id=7 -> issue.
- Fill 16 entries with DEPTH=16, tail wraps to 0 -> full high from count=13, 17th disp_valid ignored, count=16.
- Queue holds 2 committed stores and 3 loads, flush -> count=2, tail=head+2, both stores drain, no load issued.

Source files
------------

// File: rtl/lsb_queue.sv
// Purpose : in-order load/store buffer between dispatch, CDB and LSU; CDB wake-up, commit/IO gating, flush rollback.
// Latency : 1 cycle from head entry becoming eligible to lsu_valid; one op per accepted LSU handshake.
// Backpressure: full warns dispatch FULL_MARGIN slots early, disp_valid is ignored at DEPTH; LSU stalls hold the output stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable, low freezes every register
//   flush               misprediction rollback, keeps committed entries only
//   disp_*              enqueue request with operands, ROB tags and immediate
//   cdb_valid/rob/data  NUM_CDB packed broadcast channels, channel 0 in the LSBs
//   commit_valid/rob    ROB commit strobe
//   rob_head_id         ROB head id, gates loads to IO_ADDR
//   lsu_*               registered request to the LSU, valid/ready handshake
//   count, full         occupancy and early-full backpressure
module lsb_queue #(
    parameter int                 DEPTH       = 16,
    parameter int                 ROB_W       = 4,
    parameter int                 DATA_W      = 32,
    parameter int                 OP_W        = 6,
    parameter int                 NUM_CDB     = 2,
    parameter int                 FULL_MARGIN = 3,
    parameter logic [DATA_W-1:0]  IO_ADDR     = 32'h30000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,

    input  logic                        disp_valid,
    input  logic [OP_W-1:0]             disp_op,
    input  logic                        disp_is_store,
    input  logic [ROB_W-1:0]            disp_q1,
    input  logic [ROB_W-1:0]            disp_q2,
    input  logic [DATA_W-1:0]           disp_v1,
    input  logic [DATA_W-1:0]           disp_v2,
    input  logic [DATA_W-1:0]           disp_imm,
    input  logic [ROB_W-1:0]            disp_rob,

    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]    cdb_rob,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,

    input  logic                        commit_valid,
    input  logic [ROB_W-1:0]            commit_rob,
    input  logic [ROB_W-1:0]            rob_head_id,

    output logic                        lsu_valid,
    input  logic                        lsu_ready,
    output logic [OP_W-1:0]             lsu_op,
    output logic                        lsu_is_store,
    output logic [DATA_W-1:0]           lsu_addr,
    output logic [DATA_W-1:0]           lsu_data,
    output logic [ROB_W-1:0]            lsu_rob,

    output logic [$clog2(DEPTH):0]      count,
    output logic                        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic              busy;
        logic              committed;
        logic              is_store;
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  q1;
        logic [ROB_W-1:0]  q2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    entry_t          ent     [DEPTH];
    entry_t          ent_nxt [DEPTH];
    entry_t          new_ent;
    entry_t          head_ent;

    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;

    logic [DATA_W-1:0] head_addr;
    logic              head_elig;
    logic              out_free;
    logic              do_pop;
    logic              do_enq;
    logic [DEPTH-1:0]  commit_hit;
    logic [CW-1:0]     n_committed;

    logic [DATA_W:0]   byp1;
    logic [DATA_W:0]   byp2;
    logic [DATA_W:0]   wk1;
    logic [DATA_W:0]   wk2;

    // Returns {hit, data} for a tag against all valid CDB channels.
    // Tag 0 means "no dependency" and must never match a broadcast.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (tag != '0 && cdb_valid[c] && cdb_rob[c*ROB_W +: ROB_W] == tag) begin
                r = {1'b1, cdb_data[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Head eligibility and handshake
    // ------------------------------------------------------------------
    assign head_ent  = ent[head_ptr];
    assign head_addr = head_ent.v1 + head_ent.imm;

    always_comb begin
        head_elig = head_ent.busy && (head_ent.q1 == '0) && (head_ent.q2 == '0);
        if (head_ent.is_store) begin
            head_elig = head_elig && head_ent.committed;
        end else begin
            // IO loads have side effects, so they wait until non-speculative.
            head_elig = head_elig && ((head_addr != IO_ADDR) || (rob_head_id == head_ent.rob));
        end
    end

    assign out_free = !lsu_valid || lsu_ready;
    assign do_pop   = !flush && out_free && head_elig;
    assign do_enq   = !flush && disp_valid && (count != CW'(DEPTH));
    assign full     = count >= CW'(DEPTH - FULL_MARGIN);

    // ------------------------------------------------------------------
    // Commit matching and surviving-entry count for flush
    // ------------------------------------------------------------------
    always_comb begin
        commit_hit  = '0;
        n_committed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_hit[i] = commit_valid && ent[i].busy && (ent[i].rob == commit_rob);
            // A same-cycle commit counts as committed before the flush clear.
            if (ent[i].busy && (ent[i].committed || commit_hit[i])) begin
                n_committed = n_committed + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // New entry with same-cycle CDB bypass on both operands
    // ------------------------------------------------------------------
    always_comb begin
        byp1             = cdb_lookup(disp_q1);
        byp2             = cdb_lookup(disp_q2);
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.is_store = disp_is_store;
        new_ent.op       = disp_op;
        new_ent.imm      = disp_imm;
        new_ent.rob      = disp_rob;
        new_ent.q1       = byp1[DATA_W] ? '0 : disp_q1;
        new_ent.v1       = byp1[DATA_W] ? byp1[DATA_W-1:0] : disp_v1;
        new_ent.q2       = byp2[DATA_W] ? '0 : disp_q2;
        new_ent.v2       = byp2[DATA_W] ? byp2[DATA_W-1:0] : disp_v2;
    end

    // ------------------------------------------------------------------
    // Next entry state: wake-up and commit on every entry, then either the
    // flush clear or the pop/enqueue slot updates (never the same slot).
    // ------------------------------------------------------------------
    always_comb begin
        wk1 = '0;
        wk2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].busy) begin
                wk1 = cdb_lookup(ent[i].q1);
                wk2 = cdb_lookup(ent[i].q2);
                if (wk1[DATA_W]) begin
                    ent_nxt[i].q1 = '0;
                    ent_nxt[i].v1 = wk1[DATA_W-1:0];
                end
                if (wk2[DATA_W]) begin
                    ent_nxt[i].q2 = '0;
                    ent_nxt[i].v2 = wk2[DATA_W-1:0];
                end
                if (commit_hit[i]) begin
                    ent_nxt[i].committed = 1'b1;
                end
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!ent_nxt[i].committed) begin
                    ent_nxt[i] = '0;
                end
            end
        end else begin
            if (do_pop) begin
                ent_nxt[head_ptr] = '0;
            end
            if (do_enq) begin
                ent_nxt[tail_ptr] = new_ent;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers and the registered LSU output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            lsu_valid    <= 1'b0;
            lsu_op       <= '0;
            lsu_is_store <= 1'b0;
            lsu_addr     <= '0;
            lsu_data     <= '0;
            lsu_rob      <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= ent_nxt[i];
            end

            if (flush) begin
                // Committed entries sit contiguously from head, so the tail
                // collapses to just past them (DEPTH wraps back to head).
                tail_ptr <= head_ptr + PW'(n_committed);
                count    <= n_committed;
                // A speculative load in flight is dropped; a store keeps its
                // request up until the LSU takes it.
                if (!lsu_is_store || lsu_ready) begin
                    lsu_valid <= 1'b0;
                end
            end else begin
                if (do_enq) begin
                    tail_ptr <= tail_ptr + PW'(1);
                end
                if (do_pop) begin
                    head_ptr <= head_ptr + PW'(1);
                end
                count <= count + CW'(do_enq) - CW'(do_pop);

                if (out_free) begin
                    if (head_elig) begin
                        lsu_valid    <= 1'b1;
                        lsu_op       <= head_ent.op;
                        lsu_is_store <= head_ent.is_store;
                        lsu_addr     <= head_addr;
                        lsu_data     <= head_ent.is_store ? head_ent.v2 : '0;
                        lsu_rob      <= head_ent.rob;
                    end else begin
                        lsu_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
// Purpose : directed table-driven bench for lsb_queue plus multi-cycle fill and flush sequences.
// Latency : one vector per clock, outputs sampled 1 time unit after the rising edge.
// Backpressure: lsu_ready driven per vector to exercise output-stage stalls.
module tb_lsb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        disp_valid;
    logic [5:0]  disp_op;
    logic        disp_is_store;
    logic [3:0]  disp_q1, disp_q2;
    logic [31:0] disp_v1, disp_v2, disp_imm;
    logic [3:0]  disp_rob;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob;
    logic [63:0] cdb_data;
    logic        commit_valid;
    logic [3:0]  commit_rob;
    logic [3:0]  rob_head_id;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [5:0]  lsu_op;
    logic        lsu_is_store;
    logic [31:0] lsu_addr, lsu_data;
    logic [3:0]  lsu_rob;
    logic [4:0]  count;
    logic        full;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsb_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_is_store(disp_is_store),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_imm(disp_imm), .disp_rob(disp_rob),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_rob(commit_rob), .rob_head_id(rob_head_id),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_op(lsu_op),
        .lsu_is_store(lsu_is_store), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .lsu_rob(lsu_rob), .count(count), .full(full)
    );

    typedef struct {
        logic        en, fl, lr;
        logic        dv, st;
        logic [3:0]  rob, q1, q2;
        logic [31:0] v1, v2, imm;
        logic [1:0]  cv;
        logic [3:0]  cr0, cr1;
        logic [31:0] cd0, cd1;
        logic        cmv;
        logic [3:0]  cmr, rhid;
        logic        e_vld, e_st;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_rob;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t nop();
        vec_t v;
        v = '{default: '0};
        v.en = 1'b1;
        v.lr = 1'b1;
        return v;
    endfunction

    function automatic vec_t enq(input vec_t v, input logic st, input logic [3:0] rob,
                                 input logic [3:0] q1, input logic [31:0] v1,
                                 input logic [3:0] q2, input logic [31:0] v2,
                                 input logic [31:0] imm);
        vec_t r;
        r = v;
        r.dv = 1'b1; r.st = st; r.rob = rob;
        r.q1 = q1; r.v1 = v1; r.q2 = q2; r.v2 = v2; r.imm = imm;
        return r;
    endfunction

    function automatic vec_t cdb(input vec_t v, input int ch, input logic [3:0] rob, input logic [31:0] d);
        vec_t r;
        r = v;
        if (ch == 0) begin r.cv[0] = 1'b1; r.cr0 = rob; r.cd0 = d; end
        else         begin r.cv[1] = 1'b1; r.cr1 = rob; r.cd1 = d; end
        return r;
    endfunction

    function automatic vec_t cmt(input vec_t v, input logic [3:0] rob);
        vec_t r;
        r = v; r.cmv = 1'b1; r.cmr = rob;
        return r;
    endfunction

    function automatic vec_t hd(input vec_t v, input logic [3:0] id);
        vec_t r;
        r = v; r.rhid = id;
        return r;
    endfunction

    function automatic vec_t ctl(input vec_t v, input logic en, input logic fl, input logic lr);
        vec_t r;
        r = v; r.en = en; r.fl = fl; r.lr = lr;
        return r;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic vld, input logic st,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] rob, input logic [4:0] cnt);
        vec_t r;
        r = v;
        r.e_vld = vld; r.e_st = st; r.e_addr = addr; r.e_data = data; r.e_rob = rob; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        rdy           = v.en;
        flush         = v.fl;
        lsu_ready     = v.lr;
        disp_valid    = v.dv;
        disp_is_store = v.st;
        disp_op       = {2'b00, v.rob};
        disp_rob      = v.rob;
        disp_q1       = v.q1;
        disp_q2       = v.q2;
        disp_v1       = v.v1;
        disp_v2       = v.v2;
        disp_imm      = v.imm;
        cdb_valid     = v.cv;
        cdb_rob       = {v.cr1, v.cr0};
        cdb_data      = {v.cd1, v.cd0};
        commit_valid  = v.cmv;
        commit_rob    = v.cmr;
        rob_head_id   = v.rhid;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic ok;
        logic [5:0] e_op;
        apply(v);
        @(posedge clk);
        #1;
        e_op = {2'b00, v.e_rob};
        n_vec++;
        ok = (lsu_valid === v.e_vld) && (count === v.e_cnt) && (full === (v.e_cnt >= 5'd13));
        if (v.e_vld) begin
            ok = ok && (lsu_is_store === v.e_st) && (lsu_addr === v.e_addr) &&
                 (lsu_data === v.e_data) && (lsu_rob === v.e_rob) && (lsu_op === e_op);
        end
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got vld=%0b st=%0b addr=%h data=%h rob=%0d op=%0d cnt=%0d full=%0b, want vld=%0b st=%0b addr=%h data=%h rob=%0d cnt=%0d",
                     nm, lsu_valid, lsu_is_store, lsu_addr, lsu_data, lsu_rob, lsu_op, count, full,
                     v.e_vld, v.e_st, v.e_addr, v.e_data, v.e_rob, v.e_cnt);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        apply(nop());
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Basic issue, store gating, bypass, IO gating, stall, freeze, wrap, tag 0.
        vt.push_back(ex(enq(nop(), 0, 4'd1, 0, 32'h100, 0, 32'h77, 32'd4), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 1, 0, 32'h104, 0, 4'd1, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(enq(nop(), 1, 4'd2, 0, 32'h40, 4'd5, 0, 32'd8), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(cmt(nop(), 4'd5), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(cdb(nop(), 1, 4'd5, 32'hDEAD), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(cmt(nop(), 4'd2), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 1, 1, 32'h48, 32'hDEAD, 4'd2, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(cdb(enq(nop(), 0, 4'd4, 4'd3, 0, 0, 0, 32'h10), 0, 4'd3, 32'h200), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 1, 0, 32'h210, 0, 4'd4, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(hd(enq(nop(), 0, 4'd7, 0, 32'h30000, 0, 0, 0), 4'd2), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(hd(nop(), 4'd2), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(hd(nop(), 4'd7), 1, 0, 32'h30000, 0, 4'd7, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(enq(nop(), 0, 4'd8, 0, 32'h10, 0, 0, 32'd1), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(ctl(enq(nop(), 0, 4'd9, 0, 32'h20, 0, 0, 0), 1, 0, 0), 1, 0, 32'h11, 0, 4'd8, 1));
        vt.push_back(ex(ctl(nop(), 1, 0, 0), 1, 0, 32'h11, 0, 4'd8, 1));
        vt.push_back(ex(nop(), 1, 0, 32'h20, 0, 4'd9, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(enq(nop(), 0, 4'd10, 0, 32'h50, 0, 0, 0), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(ctl(enq(nop(), 0, 4'd11, 0, 32'h60, 0, 0, 0), 0, 0, 1), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 1, 0, 32'h50, 0, 4'd10, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(enq(nop(), 0, 4'd12, 0, 32'hFFFF_FFF0, 0, 0, 32'h20), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 1, 0, 32'h10, 0, 4'd12, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));
        vt.push_back(ex(cdb(enq(nop(), 0, 4'd13, 0, 32'h100, 0, 0, 0), 0, 4'd0, 32'h999), 0, 0, 0, 0, 0, 1));
        vt.push_back(ex(nop(), 1, 0, 32'h100, 0, 4'd13, 0));
        vt.push_back(ex(nop(), 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", {lsu_valid, lsu_is_store, lsu_op, lsu_rob, full, count},
                             32'd0);
        chk("reset_addr_data", lsu_addr | lsu_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Fill to DEPTH with loads that never wake; tail wraps to 0, 17th ignored.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            run_vec(ex(enq(nop(), 0, 4'(k % 15 + 1), 4'd9, 0, 0, 0, 0), 0, 0, 0, 0, 0, 5'(k)),
                    $sformatf("fill%0d", k));
        end
        chk("fill_tail_wrap", 32'(dut.tail_ptr), 32'd0);
        run_vec(ex(enq(nop(), 0, 4'd1, 0, 32'h10, 0, 0, 0), 0, 0, 0, 0, 0, 16), "fill_17th_ignored");
        run_vec(ex(ctl(nop(), 1, 1, 1), 0, 0, 0, 0, 0, 0), "fill_flush_all");

        // Two committed stores and three loads, then flush.
        do_reset();
        run_vec(ex(enq(nop(), 1, 4'd1, 0, 32'h100, 4'd6, 0, 0), 0, 0, 0, 0, 0, 1), "fl_s1");
        run_vec(ex(cmt(enq(nop(), 1, 4'd2, 0, 32'h104, 4'd6, 0, 0), 4'd1), 0, 0, 0, 0, 0, 2), "fl_s2");
        run_vec(ex(cmt(enq(nop(), 0, 4'd3, 0, 32'h200, 0, 0, 0), 4'd2), 0, 0, 0, 0, 0, 3), "fl_l3");
        run_vec(ex(enq(nop(), 0, 4'd4, 0, 32'h204, 0, 0, 0), 0, 0, 0, 0, 0, 4), "fl_l4");
        run_vec(ex(enq(nop(), 0, 4'd5, 0, 32'h208, 0, 0, 0), 0, 0, 0, 0, 0, 5), "fl_l5");
        run_vec(ex(ctl(nop(), 1, 1, 1), 0, 0, 0, 0, 0, 2), "fl_flush");
        chk("fl_tail", 32'(dut.tail_ptr), 32'd2);
        run_vec(ex(cdb(nop(), 1, 4'd6, 32'hBEEF), 0, 0, 0, 0, 0, 2), "fl_wake");
        run_vec(ex(nop(), 1, 1, 32'h100, 32'hBEEF, 4'd1, 1), "fl_drain1");
        run_vec(ex(nop(), 1, 1, 32'h104, 32'hBEEF, 4'd2, 0), "fl_drain2");
        for (int k = 0; k < 5; k++) begin
            run_vec(ex(nop(), 0, 0, 0, 0, 0, 0), $sformatf("fl_noload%0d", k));
        end

        // Commit arriving in the flush cycle survives the flush.
        run_vec(ex(enq(nop(), 1, 4'd9, 0, 32'h400, 4'd7, 0, 0), 0, 0, 0, 0, 0, 1), "fc_enq");
        run_vec(ex(cmt(ctl(nop(), 1, 1, 1), 4'd9), 0, 0, 0, 0, 0, 1), "fc_flush_commit");
        run_vec(ex(cdb(nop(), 0, 4'd7, 32'h55), 0, 0, 0, 0, 0, 1), "fc_wake");
        run_vec(ex(nop(), 1, 1, 32'h400, 32'h55, 4'd9, 0), "fc_issue");

        // Pending load is dropped by flush.
        run_vec(ex(enq(nop(), 0, 4'd10, 0, 32'h500, 0, 0, 0), 0, 0, 0, 0, 0, 1), "pl_enq");
        run_vec(ex(ctl(nop(), 1, 0, 0), 1, 0, 32'h500, 0, 4'd10, 0), "pl_issue");
        run_vec(ex(ctl(nop(), 1, 1, 0), 0, 0, 0, 0, 0, 0), "pl_flush_drop");

        // Pending store holds through flush until accepted.
        run_vec(ex(enq(nop(), 1, 4'd11, 0, 32'h600, 0, 32'h66, 0), 0, 0, 0, 0, 0, 1), "ps_enq");
        run_vec(ex(cmt(nop(), 4'd11), 0, 0, 0, 0, 0, 1), "ps_commit");
        run_vec(ex(ctl(nop(), 1, 0, 0), 1, 1, 32'h600, 32'h66, 4'd11, 0), "ps_issue");
        run_vec(ex(ctl(nop(), 1, 1, 0), 1, 1, 32'h600, 32'h66, 4'd11, 0), "ps_flush_hold");
        run_vec(ex(nop(), 0, 0, 0, 0, 0, 0), "ps_accept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
